// File: rtl/dk_audio_pkg.sv
// ----------------------------------------------------------------------------
// dk_audio_pkg
// Shared definitions for the discrete-sound audio path: the 16-bit signed
// sample type, its range limits and the saturating narrowing helper used by
// every stage that reduces a wide accumulator back to a sample.
// No ports (package).
// ----------------------------------------------------------------------------
package dk_audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  // Callers sign-extend their accumulator to 64 bits so one helper serves
  // every accumulator width in the audio chain.
  function automatic sample_t sat16(input logic signed [63:0] acc);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = 64'(SAMPLE_MAX);
    lo = 64'(SAMPLE_MIN);
    if (acc > hi) begin
      return SAMPLE_MAX;
    end else if (acc < lo) begin
      return SAMPLE_MIN;
    end else begin
      return acc[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dk_sound_mixer_pkg.sv
// ----------------------------------------------------------------------------
// dk_sound_mixer_pkg
// Mixer-local definitions: FSM state encoding and the accumulator width
// rule (sample + gain + channel-count growth + one bit for the zero-extended
// gain sign), chosen so the running sum can never overflow.
// No ports (package).
// ----------------------------------------------------------------------------
package dk_sound_mixer_pkg;
  import dk_audio_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SAT   = 2'd2
  } mix_state_t;

  function automatic int mix_acc_w(input int num_ch, input int gain_w);
    return SAMPLE_W + gain_w + $clog2(num_ch) + 1;
  endfunction

endpackage

// File: rtl/dk_sound_mixer_if.sv
// ----------------------------------------------------------------------------
// dk_sound_mixer_if
// Bundles the mixer's sample inputs, gains, strobe and mixed output.
//   audio_clk_en  sample strobe, one clk wide
//   ch_in         NUM_CH packed signed 16-bit samples, ch0 in [15:0]
//   ch_gain       NUM_CH packed unsigned Q1.(GAIN_W-1) gains
//   master_mute   forces the output sample to 0
//   mix_out       mixed, saturated sample (held between updates)
//   mix_valid     1-clk pulse when mix_out updates
//   overrun       sticky: a strobe arrived while the mixer was busy
// Modports: master = sound-generator side, slave = mixer side.
// ----------------------------------------------------------------------------
interface dk_sound_mixer_if #(
  parameter int NUM_CH = 4,
  parameter int GAIN_W = 8
);
  logic                       audio_clk_en;
  logic [NUM_CH*16-1:0]       ch_in;
  logic [NUM_CH*GAIN_W-1:0]   ch_gain;
  logic                       master_mute;
  logic signed [15:0]         mix_out;
  logic                       mix_valid;
  logic                       overrun;

  modport master (
    output audio_clk_en, ch_in, ch_gain, master_mute,
    input  mix_out, mix_valid, overrun
  );

  modport slave (
    input  audio_clk_en, ch_in, ch_gain, master_mute,
    output mix_out, mix_valid, overrun
  );
endinterface

// File: rtl/dk_mix_mac.sv
// ----------------------------------------------------------------------------
// dk_mix_mac
// Registered multiply-accumulate: acc += sample * gain, with the unsigned
// gain zero-extended so the product stays signed.
//   clk, reset_n   clock, asynchronous active-low reset
//   i_clr          clear the accumulator (wins over i_en)
//   i_en           add one product this cycle
//   i_sample       signed 16-bit sample
//   i_gain         unsigned gain
//   o_acc          current accumulator value
// ----------------------------------------------------------------------------
module dk_mix_mac
  import dk_audio_pkg::*;
#(
  parameter int GAIN_W = 8,
  parameter int ACC_W  = 27
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  sample_t                  i_sample,
  input  logic [GAIN_W-1:0]        i_gain,
  output logic signed [ACC_W-1:0]  o_acc
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  logic signed [GAIN_W:0]     w_gain_s;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_gain_s   = {1'b0, i_gain};
  assign w_prod     = PROD_W'(i_sample) * PROD_W'(w_gain_s);
  assign w_prod_ext = ACC_W'(w_prod);

  // ---- accumulate stage ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/dk_sound_mixer.sv
// ----------------------------------------------------------------------------
// dk_sound_mixer
// On each audio strobe, snapshots all channel samples, gains and the mute
// flag, then sums ch[i]*gain[i] one channel per clock on a single MAC,
// shifts out the gain's fractional bits, saturates to 16 bits and presents
// the result with a one-clock valid pulse.
//   clk, reset_n   clock, asynchronous active-low reset (sync release)
//   bus            dk_sound_mixer_if.slave (strobe, samples, gains, mute,
//                  mixed output, valid, sticky overrun)
// A strobe that arrives while a mix is in progress (ACCUM or SAT) is dropped
// and latches overrun until reset.
// ----------------------------------------------------------------------------
module dk_sound_mixer
  import dk_audio_pkg::*;
  import dk_sound_mixer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int GAIN_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  dk_sound_mixer_if.slave    bus
);

  localparam int ACC_W = mix_acc_w(NUM_CH, GAIN_W);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  mix_state_t               r_state;
  logic [IDX_W-1:0]         r_idx;
  sample_t                  r_mix_out;
  logic                     r_mix_valid;
  logic                     r_overrun;

  sample_t                  r_snap_ch   [NUM_CH];
  logic [GAIN_W-1:0]        r_snap_gain [NUM_CH];
  logic                     r_snap_mute;

  logic                     w_start;
  logic                     w_mac_en;
  sample_t                  w_mac_sample;
  logic [GAIN_W-1:0]        w_mac_gain;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [63:0]       w_wide;
  sample_t                  w_sat;

  assign w_start      = (r_state == ST_IDLE) && bus.audio_clk_en;
  assign w_mac_en     = (r_state == ST_ACCUM);
  assign w_mac_sample = r_snap_ch[r_idx];
  assign w_mac_gain   = r_snap_gain[r_idx];

  // ---- snapshot stage ----
  // Data-only registers: contents are don't-care until the first strobe, so
  // they carry no reset.
  always_ff @(posedge clk) begin
    if (w_start) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_snap_ch[i]   <= bus.ch_in[i*SAMPLE_W +: SAMPLE_W];
        r_snap_gain[i] <= bus.ch_gain[i*GAIN_W +: GAIN_W];
      end
      r_snap_mute <= bus.master_mute;
    end
  end

  // ---- multiply-accumulate stage ----
  dk_mix_mac #(
    .GAIN_W (GAIN_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (w_start),
    .i_en     (w_mac_en),
    .i_sample (w_mac_sample),
    .i_gain   (w_mac_gain),
    .o_acc    (w_acc)
  );

  // ---- saturate stage ----
  // Arithmetic shift drops the Q1.(GAIN_W-1) fraction, flooring toward -inf.
  assign w_shift = w_acc >>> (GAIN_W - 1);
  assign w_wide  = 64'(w_shift);
  assign w_sat   = r_snap_mute ? sample_t'(0) : sat16(w_wide);

  // ---- control FSM and output register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_mix_valid <= 1'b0;
      if ((r_state != ST_IDLE) && bus.audio_clk_en) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.audio_clk_en) begin
            r_idx   <= '0;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (r_idx == LAST_IDX) begin
            r_state <= ST_SAT;
          end
          r_idx <= r_idx + IDX_W'(1);
        end
        ST_SAT: begin
          r_mix_out   <= w_sat;
          r_mix_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mix_out   = r_mix_out;
  assign bus.mix_valid = r_mix_valid;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_dk_sound_mixer.sv
module tb_dk_sound_mixer;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t exp_q[$];

  dk_sound_mixer_if #(.NUM_CH(4), .GAIN_W(8)) bus ();

  dk_sound_mixer #(.NUM_CH(4), .GAIN_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT presents a sample.
  initial begin
    bit prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mix_valid) begin
        checks++;
        if (prev_valid) begin
          failures++;
          $display("FAIL valid_twice: mix_valid high two cycles in a row at cycle %0d", cyc);
        end
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got mix_out=%0d at cycle %0d, required no output", bus.mix_out, cyc);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (int'(bus.mix_out) != e.val) begin
            failures++;
            $display("FAIL mix_value: got %0d, required %0d", bus.mix_out, e.val);
          end
          checks++;
          if (cyc != e.due) begin
            failures++;
            $display("FAIL mix_latency: valid at cycle %0d, required cycle %0d", cyc, e.due);
          end
        end
      end
      prev_valid = bus.mix_valid;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_inputs(input int c0, c1, c2, c3, input int g0, g1, g2, g3, input bit mute);
    bus.ch_in       = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    bus.ch_gain     = {8'(g3), 8'(g2), 8'(g1), 8'(g0)};
    bus.master_mute = mute;
  endtask

  // Issues one strobe (caller sets inputs first) and, when an output is
  // expected, queues its value due 5 clocks after the sampling edge.
  task automatic strobe(input bit expect_out, input int exp_val);
    exp_t e;
    @(negedge clk);
    bus.audio_clk_en = 1'b1;
    if (expect_out) begin
      e.val = exp_val;
      e.due = cyc + 6;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.audio_clk_en = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.audio_clk_en = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    wait_cyc(3);
    check("reset_mix_out", int'(bus.mix_out), 0);
    check("reset_mix_valid", int'(bus.mix_valid), 0);
    check("reset_overrun", int'(bus.overrun), 0);
    reset_n = 1'b1;
    wait_cyc(2);

    // 1 unity sum
    set_inputs(1000, 2000, -500, 0, 128, 128, 128, 128, 1'b0);
    strobe(1'b1, 2500);
    wait_cyc(18);

    // 2 saturation both directions
    set_inputs(20000, 20000, 20000, 20000, 128, 128, 128, 128, 1'b0);
    strobe(1'b1, 32767);
    wait_cyc(18);
    set_inputs(-20000, -20000, -20000, -20000, 128, 128, 128, 128, 1'b0);
    strobe(1'b1, -32768);
    wait_cyc(18);

    // 3 gain and floor rounding; inputs changed right after the snapshot
    set_inputs(1001, 7000, 7000, 7000, 64, 0, 0, 0, 1'b0);
    strobe(1'b1, 500);
    wait_cyc(18);
    set_inputs(-1001, 7000, 7000, 7000, 64, 0, 0, 0, 1'b0);
    strobe(1'b1, -501);
    set_inputs(30000, 30000, 30000, 30000, 128, 128, 128, 128, 1'b1);
    wait_cyc(18);
    check("overrun_clear_before", int'(bus.overrun), 0);

    // 4 overrun: second strobe two clocks after the first is dropped
    set_inputs(1000, 2000, -500, 0, 128, 128, 128, 128, 1'b0);
    strobe(1'b1, 2500);
    set_inputs(9000, 9000, 9000, 9000, 128, 128, 128, 128, 1'b0);
    strobe(1'b0, 0);
    wait_cyc(16);
    check("overrun_set", int'(bus.overrun), 1);
    set_inputs(100, 200, 300, 400, 128, 128, 128, 128, 1'b0);
    strobe(1'b1, 1000);
    wait_cyc(18);
    check("overrun_sticky", int'(bus.overrun), 1);

    // 5 mute, then unmuted
    set_inputs(1000, 1000, 1000, 1000, 128, 128, 128, 128, 1'b1);
    strobe(1'b1, 0);
    wait_cyc(18);
    set_inputs(1000, 1000, 1000, 1000, 128, 128, 128, 128, 1'b0);
    strobe(1'b1, 4000);
    wait_cyc(18);
    check("mix_out_held", int'(bus.mix_out), 4000);
    check("overrun_sticky2", int'(bus.overrun), 1);

    // 6 reset mid-ACCUM aborts the mix
    set_inputs(1000, 2000, -500, 0, 128, 128, 128, 128, 1'b0);
    strobe(1'b0, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_mix_out", int'(bus.mix_out), 0);
    check("abort_overrun", int'(bus.overrun), 0);
    wait_cyc(16);
    strobe(1'b1, 2500);
    wait_cyc(30);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
